// File: rtl/microsequencer_if.sv
// Bundle of the microinstruction fields, condition inputs and the sequencer's
// outputs shared between the control unit (master) and the sequencer (slave).
interface microsequencer_if #(
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    // Fields of the current microinstruction, read from the ROM at `state`.
    logic              hold;
    logic [2:0]        ns_sel;
    logic [1:0]        cond_sel;
    logic              inv;
    logic [ADDR_W-1:0] cr_addr;
    logic [ADDR_W-1:0] enc_addr;

    // Condition sources.
    // Memory handshake: while the sequencer sits in WAIT_MOC it drives
    // mem_wait high until moc is seen high; the cycle moc is high the
    // wait completes and the index advances (the transfer is that cycle).
    logic              moc;
    logic              cond_pass;
    logic              flag_in;

    // Sequencer outputs; sp exposes the return-stack depth for observation.
    logic [ADDR_W-1:0] state;
    logic              mem_wait;
    logic              seq_err;
    logic [1:0]        err_code;
    logic [SP_W-1:0]   sp;

    modport master (
        output hold, ns_sel, cond_sel, inv, cr_addr, enc_addr,
        output moc, cond_pass, flag_in,
        input  state, mem_wait, seq_err, err_code, sp
    );

    modport slave (
        input  hold, ns_sel, cond_sel, inv, cr_addr, enc_addr,
        input  moc, cond_pass, flag_in,
        output state, mem_wait, seq_err, err_code, sp
    );
endinterface

// File: rtl/microsequencer.sv
// Microprogram sequencer: holds the microstore index and computes the next
// one from the current microinstruction (increment, branch, dispatch,
// subroutine call/return, and MOC wait with optional timeout).
module microsequencer #(
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4,
    parameter int MOC_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.slave  bus
);
    localparam int SP_W     = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W    = SP_W - 1;
    localparam int CNT_W    = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam int TO_LAST  = (MOC_TIMEOUT > 0) ? MOC_TIMEOUT - 1 : 0;
    localparam bit TO_EN    = (MOC_TIMEOUT > 0);

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'b000,
        NS_FETCH    = 3'b001,
        NS_INC      = 3'b010,
        NS_BRANCH   = 3'b011,
        NS_WAIT_MOC = 3'b100,
        NS_JUMP     = 3'b101,
        NS_CALL     = 3'b110,
        NS_RET      = 3'b111
    } ns_e;

    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    logic [ADDR_W-1:0] state_q;
    logic [SP_W-1:0]   sp_q;
    logic              seq_err_q;
    logic [1:0]        err_code_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic              c;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              push;
    logic              pop;
    logic              err_now;
    logic [1:0]        err_cause;

    assign inc = state_q + ADDR_W'(1);

    // Select and optionally invert the branch/wait condition.
    always_comb begin
        c = 1'b1;
        case (bus.cond_sel)
            2'b00:   c = bus.moc;
            2'b01:   c = bus.cond_pass;
            2'b10:   c = bus.flag_in;
            default: c = 1'b1;
        endcase
        c = c ^ bus.inv;
    end

    // Next-index decode, stack requests, timeout counting and error detection.
    always_comb begin
        nxt       = inc;
        cnt_nxt   = '0;
        push      = 1'b0;
        pop       = 1'b0;
        err_now   = 1'b0;
        err_cause = 2'b00;
        case (ns_e'(bus.ns_sel))
            NS_DISPATCH: nxt = bus.enc_addr;
            NS_FETCH:    nxt = '0;
            NS_INC:      nxt = inc;
            NS_BRANCH:   nxt = c ? bus.cr_addr : inc;
            NS_WAIT_MOC: begin
                if (c) begin
                    nxt = inc;
                end else if (TO_EN && cnt_q == CNT_W'(TO_LAST)) begin
                    nxt       = '0;
                    err_now   = 1'b1;
                    err_cause = ERR_TO;
                end else begin
                    nxt     = state_q;
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            NS_JUMP:     nxt = bus.cr_addr;
            NS_CALL: begin
                nxt = bus.cr_addr;
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    err_now   = 1'b1;
                    err_cause = ERR_OVF;
                end else begin
                    push = 1'b1;
                end
            end
            NS_RET: begin
                if (sp_q == '0) begin
                    nxt       = '0;
                    err_now   = 1'b1;
                    err_cause = ERR_UNF;
                end else begin
                    pop = 1'b1;
                    nxt = stack[IDX_W'(sp_q - SP_W'(1))];
                end
            end
            default:     nxt = inc;
        endcase
    end

    // Index, stack pointer, timeout counter and sticky first-error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            sp_q       <= '0;
            seq_err_q  <= 1'b0;
            err_code_q <= 2'b00;
            cnt_q      <= '0;
        end else if (!bus.hold) begin
            state_q <= nxt;
            cnt_q   <= cnt_nxt;
            if (push) begin
                sp_q <= sp_q + SP_W'(1);
            end else if (pop) begin
                sp_q <= sp_q - SP_W'(1);
            end
            if (err_now && !seq_err_q) begin
                seq_err_q  <= 1'b1;
                err_code_q <= err_cause;
            end
        end
    end

    // Return-address storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (!reset && !bus.hold && push) begin
            stack[IDX_W'(sp_q)] <= inc;
        end
    end

    assign bus.state    = state_q;
    assign bus.sp       = sp_q;
    assign bus.seq_err  = seq_err_q;
    assign bus.err_code = err_code_q;
    assign bus.mem_wait = (bus.ns_sel == NS_WAIT_MOC) && !bus.moc;
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer (ADDR_W=7, STACK_DEPTH=4, MOC_TIMEOUT=4).
module tb_microsequencer;
    localparam int ADDR_W = 7;

    localparam logic [2:0] DISPATCH = 3'b000;
    localparam logic [2:0] INC      = 3'b010;
    localparam logic [2:0] BRANCH   = 3'b011;
    localparam logic [2:0] WAITM    = 3'b100;
    localparam logic [2:0] JUMP     = 3'b101;
    localparam logic [2:0] CALL     = 3'b110;
    localparam logic [2:0] RET      = 3'b111;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    microsequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(4)) bus ();

    microsequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(4), .MOC_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] ns, input logic [1:0] cs, input logic iv,
                          input logic [6:0] cr);
        bus.ns_sel   = ns;
        bus.cond_sel = cs;
        bus.inv      = iv;
        bus.cr_addr  = cr;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.hold      = 1'b0;
        bus.enc_addr  = '0;
        bus.moc       = 1'b0;
        bus.cond_pass = 1'b0;
        bus.flag_in   = 1'b0;
        set_op(INC, 2'b11, 1'b0, 7'h00);

        // Reset state
        tick();
        check("rst_state", 32'(bus.state), 32'h0);
        check("rst_sp", 32'(bus.sp), 32'h0);
        check("rst_err", 32'(bus.seq_err), 32'h0);
        check("rst_code", 32'(bus.err_code), 32'h0);
        reset = 1'b0;

        // Increment through the whole space with wrap
        for (int i = 0; i < 128; i++) begin
            tick();
            check("inc_seq", 32'(bus.state), 32'((i + 1) % 128));
        end
        check("inc_noerr", 32'(bus.seq_err), 32'h0);

        // Branches from state 0
        bus.cond_pass = 1'b1;
        set_op(BRANCH, 2'b01, 1'b0, 7'h40); tick();
        check("br_taken", 32'(bus.state), 32'h40);
        set_op(BRANCH, 2'b01, 1'b1, 7'h40); tick();
        check("br_inv", 32'(bus.state), 32'h41);
        bus.cond_pass = 1'b0;
        set_op(BRANCH, 2'b11, 1'b0, 7'h10); tick();
        check("br_always", 32'(bus.state), 32'h10);
        bus.flag_in = 1'b0;
        set_op(BRANCH, 2'b10, 1'b0, 7'h40); tick();
        check("br_flag_nt", 32'(bus.state), 32'h11);

        // MOC wait that completes before the timeout
        set_op(JUMP, 2'b00, 1'b0, 7'h05); tick();
        set_op(WAITM, 2'b00, 1'b0, 7'h00);
        bus.moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_hi", 32'(bus.mem_wait), 32'h1);
            tick();
            check("mw_hold", 32'(bus.state), 32'h5);
        end
        bus.moc = 1'b1;
        #1;
        check("mw_lo", 32'(bus.mem_wait), 32'h0);
        tick();
        check("mw_done", 32'(bus.state), 32'h6);
        check("mw_noerr", 32'(bus.seq_err), 32'h0);

        // MOC timeout
        bus.moc = 1'b0;
        set_op(JUMP, 2'b00, 1'b0, 7'h05); tick();
        set_op(WAITM, 2'b00, 1'b0, 7'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_hold", 32'(bus.state), 32'h5);
        end
        tick();
        check("to_state", 32'(bus.state), 32'h0);
        check("to_err", 32'(bus.seq_err), 32'h1);
        check("to_code", 32'(bus.err_code), 32'h3);

        // Nested calls and returns
        do_reset();
        check("rst2_err", 32'(bus.seq_err), 32'h0);
        set_op(JUMP, 2'b11, 1'b0, 7'd10); tick();
        set_op(CALL, 2'b11, 1'b0, 7'h20); tick();
        check("call1", 32'(bus.state), 32'h20);
        check("call1_sp", 32'(bus.sp), 32'h1);
        set_op(INC, 2'b11, 1'b0, 7'h00); tick();
        check("sub_inc", 32'(bus.state), 32'h21);
        set_op(CALL, 2'b11, 1'b0, 7'h30); tick();
        check("call2", 32'(bus.state), 32'h30);
        check("call2_sp", 32'(bus.sp), 32'h2);
        set_op(RET, 2'b11, 1'b0, 7'h00); tick();
        check("ret1", 32'(bus.state), 32'h22);
        tick();
        check("ret2", 32'(bus.state), 32'd11);
        check("ret2_sp", 32'(bus.sp), 32'h0);

        // Fill the stack, then overflow
        set_op(CALL, 2'b11, 1'b0, 7'h60); tick();
        set_op(CALL, 2'b11, 1'b0, 7'h62); tick();
        set_op(CALL, 2'b11, 1'b0, 7'h64); tick();
        set_op(CALL, 2'b11, 1'b0, 7'h66); tick();
        check("full_sp", 32'(bus.sp), 32'h4);
        check("full_noerr", 32'(bus.seq_err), 32'h0);
        set_op(CALL, 2'b11, 1'b0, 7'h70); tick();
        check("ovf_state", 32'(bus.state), 32'h70);
        check("ovf_sp", 32'(bus.sp), 32'h4);
        check("ovf_err", 32'(bus.seq_err), 32'h1);
        check("ovf_code", 32'(bus.err_code), 32'h1);
        set_op(RET, 2'b11, 1'b0, 7'h00); tick();
        check("lifo1", 32'(bus.state), 32'h65);
        tick();
        check("lifo2", 32'(bus.state), 32'h63);
        tick();
        check("lifo3", 32'(bus.state), 32'h61);
        tick();
        check("lifo4", 32'(bus.state), 32'd12);
        check("lifo_sp", 32'(bus.sp), 32'h0);

        // Underflow, then a later overflow must not overwrite the code
        do_reset();
        set_op(JUMP, 2'b11, 1'b0, 7'h33); tick();
        set_op(RET, 2'b11, 1'b0, 7'h00); tick();
        check("unf_state", 32'(bus.state), 32'h0);
        check("unf_sp", 32'(bus.sp), 32'h0);
        check("unf_err", 32'(bus.seq_err), 32'h1);
        check("unf_code", 32'(bus.err_code), 32'h2);
        set_op(CALL, 2'b11, 1'b0, 7'h08);
        for (int i = 0; i < 5; i++) tick();
        check("sticky_state", 32'(bus.state), 32'h08);
        check("sticky_code", 32'(bus.err_code), 32'h2);

        // Dispatch and hold
        do_reset();
        bus.enc_addr = 7'h51;
        set_op(DISPATCH, 2'b11, 1'b0, 7'h00); tick();
        check("dispatch", 32'(bus.state), 32'h51);
        set_op(CALL, 2'b11, 1'b0, 7'h20); tick();
        check("hcall", 32'(bus.state), 32'h20);
        bus.hold = 1'b1;
        set_op(CALL, 2'b11, 1'b0, 7'h30); tick();
        check("hold_state", 32'(bus.state), 32'h20);
        check("hold_sp", 32'(bus.sp), 32'h1);
        bus.moc = 1'b0;
        set_op(WAITM, 2'b00, 1'b0, 7'h00);
        #1;
        check("hold_mw", 32'(bus.mem_wait), 32'h1);
        bus.hold = 1'b0;
        set_op(RET, 2'b11, 1'b0, 7'h00); tick();
        check("hold_stack", 32'(bus.state), 32'h52);

        // Reset wins over hold, mid-subroutine
        set_op(CALL, 2'b11, 1'b0, 7'h44); tick();
        check("pre_rst_sp", 32'(bus.sp), 32'h1);
        bus.hold = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("rsthold_state", 32'(bus.state), 32'h0);
        check("rsthold_sp", 32'(bus.sp), 32'h0);

        // Errors are not evaluated while held
        set_op(RET, 2'b11, 1'b0, 7'h00); tick();
        check("hold_noerr", 32'(bus.seq_err), 32'h0);
        check("hold_ret_state", 32'(bus.state), 32'h0);
        bus.hold = 1'b0;

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
